// File: rtl/cv32e40x_xif_result_queue.sv
// In-order result/commit tracker between the XIF issue stage and the XIF result channel.
// Latency: result valid one cycle after the later of FU write and commit (0 with bypass).
// Backpressure: alloc_ready_o drops when full (not pop-aware); the head result holds until result_ready_i.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   alloc_*                      allocate one entry per accepted offloaded instruction
//   fu_*                         functional-unit result, matched to an entry by ID
//   commit_*                     commit/kill decision, matched to a pending entry by ID
//   result_*                     XIF result channel, emitted strictly in issue order
//   count_o                      number of occupied entries
//   err_o                        sticky: an fu/commit strobe matched no live entry
//
// Optional feature macro: XIF_RESULT_BYPASS_EN
//   When defined, an FU result for a committed (or committing) head that is not yet done
//   is forwarded straight to the result port in the same cycle.
module cv32e40x_xif_result_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFW_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [X_ID_WIDTH-1:0]      alloc_id_i,
    input  logic [4:0]                 alloc_rd_i,
    input  logic                       fu_valid_i,
    input  logic [X_ID_WIDTH-1:0]      fu_id_i,
    input  logic [X_RFW_WIDTH-1:0]     fu_data_i,
    input  logic                       commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]      commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [X_ID_WIDTH-1:0]      result_id_o,
    output logic [4:0]                 result_rd_o,
    output logic [X_RFW_WIDTH-1:0]     result_data_o,
    output logic                       result_we_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        CS_FREE,
        CS_PEND,
        CS_COMMIT,
        CS_KILL
    } cstate_e;

    cstate_e                cs_q   [DEPTH];
    cstate_e                cs_d   [DEPTH];
    logic                   done_q [DEPTH];
    logic                   done_d [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_d   [DEPTH];
    logic [4:0]             rd_q   [DEPTH];
    logic [4:0]             rd_d   [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_d [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [DEPTH-1:0] fu_match;
    logic [DEPTH-1:0] commit_match;
    logic             do_alloc;
    logic             commit_alloc;
    logic             pop;
    logic             head_kill;
    logic             head_ready;
    logic             byp;
    cstate_e          commit_cs;

    // Match fu/commit strobes against live entries. The entry being allocated this
    // cycle is not yet live, so an FU strobe for it counts as a miss.
    always_comb begin
        fu_match     = '0;
        commit_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fu_match[i]     = (cs_q[i] != CS_FREE) && (id_q[i] == fu_id_i);
            commit_match[i] = (cs_q[i] == CS_PEND) && (id_q[i] == commit_id_i);
        end
    end

    assign alloc_ready_o = (count_q != FULL_CNT);
    assign do_alloc      = alloc_valid_i && alloc_ready_o;
    assign commit_alloc  = commit_valid_i && do_alloc && (alloc_id_i == commit_id_i);
    assign commit_cs     = commit_kill_i ? CS_KILL : CS_COMMIT;

    assign head_kill  = (cs_q[head_q] == CS_KILL);
    assign head_ready = (cs_q[head_q] == CS_COMMIT) && done_q[head_q];

`ifdef XIF_RESULT_BYPASS_EN
    // Forward the FU result when the head is committed, or committing now, but not done.
    assign byp = fu_valid_i && fu_match[head_q] && !done_q[head_q] &&
                 ((cs_q[head_q] == CS_COMMIT) ||
                  ((cs_q[head_q] == CS_PEND) && commit_valid_i && !commit_kill_i &&
                   (commit_id_i == id_q[head_q])));
    assign result_data_o = byp ? fu_data_i : data_q[head_q];
`else
    assign byp           = 1'b0;
    assign result_data_o = data_q[head_q];
`endif

    assign result_valid_o = head_ready || byp;
    assign result_id_o    = id_q[head_q];
    assign result_rd_o    = rd_q[head_q];
    assign result_we_o    = result_valid_o;
    assign count_o        = count_q;
    assign err_o          = err_q;

    // Killed heads retire silently regardless of done; committed heads wait for ready.
    assign pop = head_kill || (result_valid_o && result_ready_i);

    always_comb begin
        cs_d    = cs_q;
        done_d  = done_q;
        id_d    = id_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (fu_valid_i && fu_match[i]) begin
                data_d[i] = fu_data_i;
                done_d[i] = 1'b1;
            end
            if (commit_valid_i && commit_match[i]) begin
                cs_d[i] = commit_cs;
            end
        end

        if (pop) begin
            cs_d[head_q]   = CS_FREE;
            done_d[head_q] = 1'b0;
            head_d         = head_q + PW'(1);
        end

        // Tail slot is free whenever allocation is allowed, so it never collides with the pop.
        if (do_alloc) begin
            id_d[tail_q]   = alloc_id_i;
            rd_d[tail_q]   = alloc_rd_i;
            done_d[tail_q] = 1'b0;
            cs_d[tail_q]   = commit_alloc ? commit_cs : CS_PEND;
            tail_d         = tail_q + PW'(1);
        end

        if (do_alloc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_alloc && pop) begin
            count_d = count_q - CW'(1);
        end

        if ((fu_valid_i && !(|fu_match)) ||
            (commit_valid_i && !(|commit_match) && !commit_alloc)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_q    <= '{default: CS_FREE};
            done_q  <= '{default: 1'b0};
            id_q    <= '{default: '0};
            rd_q    <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cs_q    <= cs_d;
            done_q  <= done_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cv32e40x_xif_result_queue.sv
// Directed testbench for cv32e40x_xif_result_queue with hand-computed expectations.
// Latency: stimulus applied 1ns after a rising edge; outputs sampled 1ns after the next edge.
// Backpressure: result_ready_i is driven explicitly per scenario.
module tb_cv32e40x_xif_result_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [3:0]  alloc_id_i;
    logic [4:0]  alloc_rd_i;
    logic        fu_valid_i;
    logic [3:0]  fu_id_i;
    logic [31:0] fu_data_i;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic [2:0]  count_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    cv32e40x_xif_result_queue #(
        .DEPTH       (4),
        .X_ID_WIDTH  (4),
        .X_RFW_WIDTH (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_id_i     (alloc_id_i),
        .alloc_rd_i     (alloc_rd_i),
        .fu_valid_i     (fu_valid_i),
        .fu_id_i        (fu_id_i),
        .fu_data_i      (fu_data_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_rd_o    (result_rd_o),
        .result_data_o  (result_data_o),
        .result_we_o    (result_we_o),
        .count_o        (count_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_alloc(input logic [3:0] id, input logic [4:0] rd);
        alloc_valid_i = 1'b1;
        alloc_id_i    = id;
        alloc_rd_i    = rd;
        tick();
        alloc_valid_i = 1'b0;
    endtask

    task automatic do_fu(input logic [3:0] id, input logic [31:0] data);
        fu_valid_i = 1'b1;
        fu_id_i    = id;
        fu_data_i  = data;
        tick();
        fu_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
    endtask

    task automatic do_pop();
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    initial begin
        logic [3:0] rid;
        rst_i          = 1'b1;
        alloc_valid_i  = 1'b0;
        alloc_id_i     = '0;
        alloc_rd_i     = '0;
        fu_valid_i     = 1'b0;
        fu_id_i        = '0;
        fu_data_i      = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        result_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(alloc_ready_o), 32'd1);
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        // Single instruction: alloc, FU, commit
        do_alloc(4'd3, 5'd5);
        chk("t1_count_alloc", 32'(count_o), 32'd1);
        do_fu(4'd3, 32'hDEADBEEF);
        chk("t1_valid_pre_commit", 32'(result_valid_o), 32'd0);
        do_commit(4'd3, 1'b0);
        chk("t1_valid", 32'(result_valid_o), 32'd1);
        chk("t1_we", 32'(result_we_o), 32'd1);
        chk("t1_id", 32'(result_id_o), 32'd3);
        chk("t1_rd", 32'(result_rd_o), 32'd5);
        chk("t1_data", result_data_o, 32'hDEADBEEF);
        do_pop();
        chk("t1_count_after", 32'(count_o), 32'd0);
        chk("t1_valid_after", 32'(result_valid_o), 32'd0);

        // Out-of-order FU results, in-order emission
        do_alloc(4'd1, 5'd1);
        do_alloc(4'd2, 5'd2);
        do_fu(4'd2, 32'h22);
        do_fu(4'd1, 32'h11);
        do_commit(4'd1, 1'b0);
        do_commit(4'd2, 1'b0);
        chk("t2_first_id", 32'(result_id_o), 32'd1);
        chk("t2_first_data", result_data_o, 32'h11);
        do_pop();
        chk("t2_second_valid", 32'(result_valid_o), 32'd1);
        chk("t2_second_id", 32'(result_id_o), 32'd2);
        chk("t2_second_data", result_data_o, 32'h22);
        do_pop();
        chk("t2_count", 32'(count_o), 32'd0);

        // Kill 4, commit 5: only 5 emitted
        do_alloc(4'd4, 5'd4);
        do_alloc(4'd5, 5'd6);
        do_fu(4'd4, 32'h44);
        do_fu(4'd5, 32'h55);
        do_commit(4'd4, 1'b1);
        chk("t3_kill_head_no_valid", 32'(result_valid_o), 32'd0);
        chk("t3_count_before_pop", 32'(count_o), 32'd2);
        do_commit(4'd5, 1'b0);
        chk("t3_count_after_kill", 32'(count_o), 32'd1);
        chk("t3_valid", 32'(result_valid_o), 32'd1);
        chk("t3_id", 32'(result_id_o), 32'd5);
        chk("t3_rd", 32'(result_rd_o), 32'd6);
        chk("t3_data", result_data_o, 32'h55);
        do_pop();
        chk("t3_count", 32'(count_o), 32'd0);
        chk("t3_err", 32'(err_o), 32'd0);

        // Fill to DEPTH, refused 5th alloc, partial drain
        for (int i = 0; i < 4; i++) do_alloc(4'(i), 5'(i + 8));
        chk("t4_full_ready", 32'(alloc_ready_o), 32'd0);
        chk("t4_full_count", 32'(count_o), 32'd4);
        do_alloc(4'd7, 5'd7);
        chk("t4_refused_count", 32'(count_o), 32'd4);
        for (int i = 0; i < 4; i++) do_fu(4'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) do_commit(4'(i), 1'b0);
        chk("t4_head_id", 32'(result_id_o), 32'd0);
        chk("t4_head_rd", 32'(result_rd_o), 32'd8);
        do_pop();
        chk("t4_ready_after_pop", 32'(alloc_ready_o), 32'd1);
        chk("t4_count_after_pop", 32'(count_o), 32'd3);
        for (int i = 1; i < 4; i++) begin
            chk("t4_drain_id", 32'(result_id_o), 32'(i));
            chk("t4_drain_data", result_data_o, 32'h100 + 32'(i));
            do_pop();
        end
        chk("t4_empty", 32'(count_o), 32'd0);

        // Three full refills exercising pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                rid = {2'(r), 2'(i)};
                do_alloc(rid, 5'(i));
            end
            chk("t4_refill_full", 32'(alloc_ready_o), 32'd0);
            for (int i = 0; i < 4; i++) begin
                rid = {2'(r), 2'(i)};
                do_fu(rid, 32'hA000 + 32'(r * 16 + i));
            end
            for (int i = 0; i < 4; i++) begin
                rid = {2'(r), 2'(i)};
                do_commit(rid, 1'b0);
            end
            for (int i = 0; i < 4; i++) begin
                chk("t4_refill_id", 32'(result_id_o), 32'(r * 4 + i));
                chk("t4_refill_data", result_data_o, 32'hA000 + 32'(r * 16 + i));
                do_pop();
            end
            chk("t4_refill_empty", 32'(count_o), 32'd0);
        end
        chk("t4_err", 32'(err_o), 32'd0);

        // Backpressure hold then reset mid-hold
        do_alloc(4'd10, 5'd3);
        do_fu(4'd10, 32'h5A5A5A5A);
        do_commit(4'd10, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", 32'(result_valid_o), 32'd1);
            chk("t5_hold_id", 32'(result_id_o), 32'd10);
            chk("t5_hold_data", result_data_o, 32'h5A5A5A5A);
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t5_rst_valid", 32'(result_valid_o), 32'd0);
        chk("t5_rst_count", 32'(count_o), 32'd0);
        tick();
        chk("t5_rst_valid_later", 32'(result_valid_o), 32'd0);

        // Orphan FU strobe
        do_fu(4'd9, 32'h99);
        chk("t6_err", 32'(err_o), 32'd1);
        chk("t6_count", 32'(count_o), 32'd0);
        chk("t6_valid", 32'(result_valid_o), 32'd0);

        // Committed head, FU arrives later: bypass vs registered path
        do_alloc(4'd6, 5'd1);
        do_commit(4'd6, 1'b0);
        chk("t7_valid_not_done", 32'(result_valid_o), 32'd0);
        fu_valid_i = 1'b1;
        fu_id_i    = 4'd6;
        fu_data_i  = 32'hCAFEF00D;
        #1;
`ifdef XIF_RESULT_BYPASS_EN
        chk("t7_same_cycle_valid", 32'(result_valid_o), 32'd1);
        chk("t7_same_cycle_data", result_data_o, 32'hCAFEF00D);
`else
        chk("t7_same_cycle_valid", 32'(result_valid_o), 32'd0);
`endif
        tick();
        fu_valid_i = 1'b0;
        chk("t7_next_valid", 32'(result_valid_o), 32'd1);
        chk("t7_next_data", result_data_o, 32'hCAFEF00D);
        do_pop();
        chk("t7_count", 32'(count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
